// File: rtl/alu_pkg.sv
// Definitions shared by the ALU, the instruction decoder and the execute/writeback stage:
// condition codes, NZCV bit positions and ALU operation encodings.
package alu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_NOT = 4'b0101,
        OP_SHL = 4'b0110,
        OP_SHR = 4'b0111,
        OP_MUL = 4'b1000,
        OP_CMP = 4'b1001,
        OP_COS = 4'b1010,
        OP_SIN = 4'b1011
    } alu_op_e;

endpackage

// File: rtl/ex_condlogic_buffer_cond_check.sv
// Combinational ARM-style condition evaluator: decides whether an instruction
// executes given its condition field and the architectural NZCV flags.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n_f, z_f, c_f, v_f;

    assign n_f = nzcv[FLAG_N];
    assign z_f = nzcv[FLAG_Z];
    assign c_f = nzcv[FLAG_C];
    assign v_f = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b1;
        case (cond_e'(cond))
            COND_EQ: pass = z_f;
            COND_NE: pass = !z_f;
            COND_CS: pass = c_f;
            COND_CC: pass = !c_f;
            COND_MI: pass = n_f;
            COND_PL: pass = !n_f;
            COND_VS: pass = v_f;
            COND_VC: pass = !v_f;
            COND_HI: pass = c_f && !z_f;
            COND_LS: pass = !c_f || z_f;
            COND_GE: pass = (n_f == v_f);
            COND_LT: pass = (n_f != v_f);
            COND_GT: pass = !z_f && (n_f == v_f);
            COND_LE: pass = z_f || (n_f != v_f);
            // NV is never-execute on real ARM; this pipeline executes it unconditionally.
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_condlogic_buffer.sv
// Execute-to-writeback stage: conditionally retires ALU results, maintains NZCV
// and queues passing instructions in a 2-entry valid/ready buffer.
module ex_condlogic_buffer
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    input  logic [3:0]   cond,
    input  logic [1:0]   flag_write,
    input  logic         reg_write,
    input  logic [3:0]   rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_rd,
    output logic         out_reg_write,
    output logic [3:0]   nzcv
);

    localparam int DEPTH = 2;

    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [3:0]   nzcv_q, nzcv_d;

    logic [N-1:0] result_mem_q [DEPTH];
    logic [3:0]   rd_mem_q     [DEPTH];
    logic         rw_mem_q     [DEPTH];

    logic             cond_pass;
    logic             accept;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] wr_en;
    logic             head_idx;

    cond_check u_cond_check (
        .cond (cond),
        .nzcv (nzcv_q),
        .pass (cond_pass)
    );

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    // A failed condition still completes the handshake but leaves no trace.
    assign push      = accept && cond_pass;
    assign pop       = out_valid && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_q == 1'(gi));
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    assign wr_ptr_d = wr_ptr_q ^ push;
    assign rd_ptr_d = rd_ptr_q ^ pop;

    always_comb begin
        nzcv_d = nzcv_q;
        if (push && flag_write[1]) begin
            nzcv_d[FLAG_N] = alu_flags[FLAG_N];
            nzcv_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (push && flag_write[0]) begin
            nzcv_d[FLAG_C] = alu_flags[FLAG_C];
            nzcv_d[FLAG_V] = alu_flags[FLAG_V];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            nzcv_q   <= 4'b0000;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            nzcv_q   <= nzcv_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                result_mem_q[i] <= '0;
                rd_mem_q[i]     <= 4'd0;
                rw_mem_q[i]     <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    result_mem_q[i] <= alu_result;
                    rd_mem_q[i]     <= rd;
                    rw_mem_q[i]     <= reg_write;
                end
            end
        end
    end

    // When empty, the slot behind the read pointer still holds the last popped entry.
    assign head_idx      = out_valid ? rd_ptr_q : ~rd_ptr_q;
    assign out_result    = result_mem_q[head_idx];
    assign out_rd        = rd_mem_q[head_idx];
    assign out_reg_write = rw_mem_q[head_idx];
    assign nzcv          = nzcv_q;

endmodule
